// File: rtl/uart_pkg.sv
// Shared types for the UART transmit framer: FSM state encoding, byte type and
// the default start-of-frame marker.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    GAP,
    WAIT_DONE
  } state_t;

  localparam byte_t SOF_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Message ingress and transmitter byte handshake bundled for the framer.
// The slave modport is the framer side; master is the upstream/transmitter side.
interface uart_tx_framer_if #(
  parameter int MSG_BYTES = 4
);
  import uart_pkg::*;

  // msg: a message transfers on every rising clk edge where msg_valid && msg_ready;
  // msg_data must be stable while msg_valid is high. tx: tx_start is a level
  // request with tx_data held until tx_busy is seen, then released.
  logic                   msg_valid;
  logic                   msg_ready;
  logic [8*MSG_BYTES-1:0] msg_data;
  logic                   tx_start;
  byte_t                  tx_data;
  logic                   tx_busy;

  modport master (
    output msg_valid, msg_data, tx_busy,
    input  msg_ready, tx_start, tx_data
  );

  modport slave (
    input  msg_valid, msg_data, tx_busy,
    output msg_ready, tx_start, tx_data
  );

endinterface

// File: rtl/uart_tx_framer_msg_fifo.sv
// Synchronous message FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate counter register.
module msg_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push is refused when full even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/uart_tx_framer.sv
// Frames queued messages as SOF + payload (MSB byte first) and feeds them to a
// byte-wide UART transmitter. Define TX_FRAMER_CHECKSUM_EN to append an XOR byte.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int    MSG_BYTES    = 4,
  parameter int    FIFO_DEPTH   = 4,
  parameter byte_t SOF_BYTE     = SOF_DEFAULT,
  parameter int    BUSY_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_framer_if.slave               bus,
  output logic                          frame_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_timeout,
  output state_t                        fsm_state
);

  localparam int IDX_W = $clog2(MSG_BYTES+3);
  localparam int TW    = $clog2(BUSY_TIMEOUT+1);
`ifdef TX_FRAMER_CHECKSUM_EN
  localparam int LAST_IDX = MSG_BYTES + 1;
`else
  localparam int LAST_IDX = MSG_BYTES;
`endif

  state_t                 state, state_next;
  logic [IDX_W-1:0]       byte_idx, byte_idx_next;
  logic [8*MSG_BYTES-1:0] frame, frame_next;
  logic [TW-1:0]          timer, timer_next;
  logic                   tx_start_q, tx_start_next;
  byte_t                  tx_data_q, tx_data_next;
  logic                   err_q, err_set;
  logic                   pop, full, empty, is_payload;
  logic [8*MSG_BYTES-1:0] payload;
  byte_t                  cur_byte;
`ifdef TX_FRAMER_CHECKSUM_EN
  byte_t                  csum, csum_next;
`endif

  msg_fifo #(
    .WIDTH (8*MSG_BYTES),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.msg_valid),
    .pop   (pop),
    .wdata (bus.msg_data),
    .rdata (payload),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // Payload bytes are consumed from the top of a left-shifting frame register.
  assign is_payload = (byte_idx != '0) && (byte_idx <= IDX_W'(MSG_BYTES));

  always_comb begin
    cur_byte = frame[8*MSG_BYTES-1 -: 8];
    if (byte_idx == '0) cur_byte = SOF_BYTE;
`ifdef TX_FRAMER_CHECKSUM_EN
    else if (byte_idx == IDX_W'(LAST_IDX)) cur_byte = csum;
`endif
  end

  always_comb begin
    state_next    = state;
    byte_idx_next = byte_idx;
    frame_next    = frame;
    timer_next    = timer;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_q;
    err_set       = 1'b0;
    pop           = 1'b0;
`ifdef TX_FRAMER_CHECKSUM_EN
    csum_next     = csum;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          pop           = 1'b1;
          frame_next    = payload;
          byte_idx_next = '0;
`ifdef TX_FRAMER_CHECKSUM_EN
          csum_next     = '0;
`endif
          state_next    = LOAD;
        end
      end
      LOAD: begin
        tx_data_next = cur_byte;
        timer_next   = '0;
        state_next   = REQ;
        if (is_payload) begin
          frame_next = frame << 8;
`ifdef TX_FRAMER_CHECKSUM_EN
          csum_next  = csum ^ cur_byte;
`endif
        end
      end
      REQ: begin
        // tx_start lags REQ entry by one cycle; timer counts cycles it is high.
        if (bus.tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer == TW'(BUSY_TIMEOUT)) begin
          err_set    = 1'b1;
          state_next = GAP;
        end else begin
          timer_next    = timer + 1'b1;
          tx_start_next = 1'b1;
        end
      end
      GAP: begin
        timer_next    = TW'(1);
        tx_start_next = 1'b1;
        state_next    = REQ;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (byte_idx == IDX_W'(LAST_IDX)) begin
            state_next = IDLE;
          end else begin
            byte_idx_next = byte_idx + 1'b1;
            state_next    = LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_idx   <= '0;
      frame      <= '0;
      timer      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
`ifdef TX_FRAMER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_next;
      byte_idx   <= byte_idx_next;
      frame      <= frame_next;
      timer      <= timer_next;
      tx_start_q <= tx_start_next;
      tx_data_q  <= tx_data_next;
      err_q      <= err_q | err_set;
`ifdef TX_FRAMER_CHECKSUM_EN
      csum       <= csum_next;
`endif
    end
  end

  assign bus.msg_ready = !full;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign frame_busy    = (state != IDLE);
  assign err_timeout   = err_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with a behavioural transmitter and a byte
// scoreboard; follows TX_FRAMER_CHECKSUM_EN to decide the expected frame.
module tb_uart_tx_framer;
  import uart_pkg::*;

  localparam int MSG_BYTES    = 4;
  localparam int FIFO_DEPTH   = 4;
  localparam int BUSY_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_busy;
  logic [2:0] fifo_count;
  logic       err_timeout;
  state_t     fsm_state;

  uart_tx_framer_if #(.MSG_BYTES(MSG_BYTES)) bus ();

  uart_tx_framer #(
    .MSG_BYTES    (MSG_BYTES),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .SOF_BYTE     (8'hAA),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .frame_busy  (frame_busy),
    .fifo_count  (fifo_count),
    .err_timeout (err_timeout),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         model_mode = 0;   // 0: responsive transmitter, 1: never raises busy
  logic       model_active = 1'b0;
  int         bytes_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_msg(input logic [31:0] d);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hAA);
    for (int i = MSG_BYTES-1; i >= 0; i--) begin
      exp_q.push_back(d[8*i +: 8]);
      x = x ^ d[8*i +: 8];
    end
`ifdef TX_FRAMER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_msg(input logic [31:0] d, output int waited);
    bus.msg_valid = 1'b1;
    bus.msg_data  = d;
    waited = 0;
    while (!bus.msg_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("push_accept", {31'b0, bus.msg_ready}, 1);
    if (bus.msg_ready) expect_msg(d);
    @(negedge clk);
    bus.msg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((frame_busy || fifo_count != 0 || exp_q.size() != 0 || model_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'b0, n < budget}, 1);
  endtask

  // behavioural transmitter: busy 3 cycles after tx_start seen, held 20 cycles
  initial begin
    logic [7:0] e;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_mode == 0 && rst_n && bus.tx_start) begin
        model_active = 1'b1;
        bytes_seen++;
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL tx_byte_unexpected: observed %h expected none", bus.tx_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_byte", {24'b0, bus.tx_data}, {24'b0, e});
          vectors--;
        end
        repeat (3) @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat (20) @(negedge clk);
        bus.tx_busy = 1'b0;
        model_active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, n;
    bus.msg_valid = 1'b0;
    bus.msg_data  = '0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_tx_start", {31'b0, bus.tx_start}, 0);
    check("rst_tx_data", {24'b0, bus.tx_data}, 0);
    check("rst_frame_busy", {31'b0, frame_busy}, 0);
    check("rst_fifo_count", {29'b0, fifo_count}, 0);
    check("rst_err", {31'b0, err_timeout}, 0);
    check("rst_ready", {31'b0, bus.msg_ready}, 1);
    check("rst_state", fsm_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // single message and first-byte latency
    push_msg(32'h11223344, w);
    check("lat_count_n0", {29'b0, fifo_count}, 1);
    check("lat_start_n0", {31'b0, bus.tx_start}, 0);
    @(negedge clk);
    check("lat_busy_n1", {31'b0, frame_busy}, 1);
    check("lat_count_n1", {29'b0, fifo_count}, 0);
    check("lat_state_n1", fsm_state, LOAD);
    @(negedge clk);
    check("lat_start_n2", {31'b0, bus.tx_start}, 0);
    check("lat_data_n2", {24'b0, bus.tx_data}, 32'hAA);
    @(negedge clk);
    check("lat_start_n3", {31'b0, bus.tx_start}, 1);
    check("lat_data_n3", {24'b0, bus.tx_data}, 32'hAA);
    wait_idle(2000);
    check("single_frame_busy", {31'b0, frame_busy}, 0);
    check("single_err", {31'b0, err_timeout}, 0);

    // FIFO fill behind an in-flight frame, then a push that must wait
    push_msg(32'hA0A1A2A3, w);
    push_msg(32'hB0B1B2B3, w);
    push_msg(32'hC0C1C2C3, w);
    push_msg(32'hD0D1D2D3, w);
    push_msg(32'hE0E1E2E3, w);
    check("full_ready", {31'b0, bus.msg_ready}, 0);
    check("full_count", {29'b0, fifo_count}, 4);
    push_msg(32'hF0F1F2F3, w);
    check("full_push_waited", {31'b0, w > 0}, 1);
    check("full_count_refill", {29'b0, fifo_count}, 4);
    wait_idle(5000);

    // simultaneous push and pop with two messages queued
    push_msg(32'h01020304, w);
    push_msg(32'h05060708, w);
    push_msg(32'h090A0B0C, w);
    n = 0;
    while (fsm_state != IDLE && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("pp_idle_seen", fsm_state, IDLE);
    check("pp_count_before", {29'b0, fifo_count}, 2);
    push_msg(32'h0D0E0F10, w);
    check("pp_count_after", {29'b0, fifo_count}, 2);
    check("pp_popped", {31'b0, frame_busy}, 1);
    wait_idle(3000);

    // transmitter never answers: timeout, gap, retry of the same byte
    model_mode = 1;
    push_msg(32'h5A5B5C5D, w);
    n = 0;
    while (!bus.tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.tx_start && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("to_high_cycles", n, BUSY_TIMEOUT);
    check("to_err", {31'b0, err_timeout}, 1);
    check("to_state_gap", fsm_state, GAP);
    @(negedge clk);
    check("to_retry_start", {31'b0, bus.tx_start}, 1);
    check("to_retry_data", {24'b0, bus.tx_data}, 32'hAA);
    model_mode = 0;
    wait_idle(2000);
    check("to_err_sticky", {31'b0, err_timeout}, 1);

    // reset during the third byte of a frame
    n = bytes_seen;
    push_msg(32'h31323334, w);
    push_msg(32'h41424344, w);
    w = 0;
    while (bytes_seen < n + 3 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("mr_queued", {29'b0, fifo_count}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_tx_start", {31'b0, bus.tx_start}, 0);
    check("mr_tx_data", {24'b0, bus.tx_data}, 0);
    check("mr_frame_busy", {31'b0, frame_busy}, 0);
    check("mr_fifo_count", {29'b0, fifo_count}, 0);
    check("mr_ready", {31'b0, bus.msg_ready}, 1);
    check("mr_err", {31'b0, err_timeout}, 0);
    check("mr_state", fsm_state, IDLE);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    while (model_active && w < 100) begin
      @(negedge clk);
      w++;
    end
    push_msg(32'hDEADBEEF, w);
    wait_idle(2000);
    check("end_queue_empty", exp_q.size(), 0);
    check("end_state", fsm_state, IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
